// File: rtl/pipe_pkg.sv
// Shared ID/EX pipeline types: control bundle, bubble constant, hazard FSM states.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational stall-length decode (0/1/2 bubbles) for the ID instruction.
// Branch-operand rules exist only when ID_BRANCH_HAZARD_EN is defined.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             id_ex_mem_read_i,
  input  logic             id_ex_reg_write_i,
  input  logic [REG_W-1:0] id_ex_rt_i,
  input  logic [REG_W-1:0] id_ex_dest_i,
  input  logic [REG_W-1:0] if_id_rs_i,
  input  logic [REG_W-1:0] if_id_rt_i,
  input  logic             id_branch_i,
  input  logic             ex_mem_mem_read_i,
  input  logic [REG_W-1:0] ex_mem_rd_i,
  output logic [1:0]       stall_len_o
);

  logic load_use;
  assign load_use = id_ex_mem_read_i && (id_ex_rt_i != '0) &&
                    ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));

`ifdef ID_BRANCH_HAZARD_EN
  logic dest_hit;
  logic mem_hit;
  assign dest_hit = (id_ex_dest_i != '0) &&
                    ((id_ex_dest_i == if_id_rs_i) || (id_ex_dest_i == if_id_rt_i));
  assign mem_hit  = (ex_mem_rd_i != '0) &&
                    ((ex_mem_rd_i == if_id_rs_i) || (ex_mem_rd_i == if_id_rt_i));

  // Branch-after-load is tested ahead of load-use: a load's dest is its Rt,
  // so load-use would otherwise always shadow the two-bubble case.
  always_comb begin
    stall_len_o = 2'd0;
    if (id_branch_i && id_ex_mem_read_i && dest_hit) begin
      stall_len_o = 2'd2;
    end else if (load_use) begin
      stall_len_o = 2'd1;
    end else if (id_branch_i && id_ex_reg_write_i && dest_hit) begin
      stall_len_o = 2'd1;
    end else if (id_branch_i && ex_mem_mem_read_i && mem_hit) begin
      stall_len_o = 2'd1;
    end
  end
`else
  logic unused_branch_inputs;
  assign unused_branch_inputs = ^{id_ex_reg_write_i, id_ex_dest_i, id_branch_i,
                                  ex_mem_mem_read_i, ex_mem_rd_i};
  assign stall_len_o = {1'b0, load_use};
`endif

endmodule

// File: rtl/hazard_id_ex_stage.sv
// ID/EX pipeline register with load-use / branch-operand stall FSM and stall counter.
// Branch hazard rules are built only when ID_BRANCH_HAZARD_EN is defined.
module hazard_id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  IF_ID_Reg_Rs,
  input  logic [REG_W-1:0]  IF_ID_Reg_Rt,
  input  logic [REG_W-1:0]  IF_ID_Reg_Rd,
  input  logic [DATA_W-1:0] ID_Rs_Data,
  input  logic [DATA_W-1:0] ID_Rt_Data,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_MemtoReg,
  input  logic              ID_RegDst,
  input  logic              ID_ALUSrc,
  input  logic              ID_Branch,
  input  logic [1:0]        ID_ALUOp,
  input  logic [REG_W-1:0]  EX_MEM_Reg_Rd,
  input  logic              EX_MEM_MemRead,
  input  logic              ID_EX_Flush,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic              Hazard_Stall,
  output logic [REG_W-1:0]  ID_EX_Reg_Rs,
  output logic [REG_W-1:0]  ID_EX_Reg_Rt,
  output logic [REG_W-1:0]  ID_EX_Reg_Rd,
  output logic [DATA_W-1:0] ID_EX_Rs_Data,
  output logic [DATA_W-1:0] ID_EX_Rt_Data,
  output logic [DATA_W-1:0] ID_EX_Imm,
  output logic              ID_EX_RegWrite,
  output logic              ID_EX_MemRead,
  output logic              ID_EX_MemWrite,
  output logic              ID_EX_MemtoReg,
  output logic              ID_EX_RegDst,
  output logic              ID_EX_ALUSrc,
  output logic              ID_EX_Branch,
  output logic [1:0]        ID_EX_ALUOp,
  output logic [31:0]       Stall_Cycles
);

  hz_state_e         state_q, state_d;
  logic [1:0]        stall_cnt_q, stall_cnt_d;
  id_ex_ctrl_t       ctrl_q, ctrl_d, id_ctrl;
  logic [REG_W-1:0]  rs_q, rt_q, rd_q, id_ex_dest;
  logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
  logic [31:0]       stall_cycles_q, stall_cycles_d;
  logic [1:0]        stall_len;
  logic              bubble;
  logic              hazard_stall;

  assign id_ctrl = '{reg_write: ID_RegWrite, mem_read: ID_MemRead, mem_write: ID_MemWrite,
                     mem_to_reg: ID_MemtoReg, reg_dst: ID_RegDst, alu_src: ID_ALUSrc,
                     branch: ID_Branch, alu_op: ID_ALUOp};

  assign id_ex_dest = ctrl_q.reg_dst ? rd_q : rt_q;

  hazard_detect #(.REG_W(REG_W)) u_detect (
    .id_ex_mem_read_i (ctrl_q.mem_read),
    .id_ex_reg_write_i(ctrl_q.reg_write),
    .id_ex_rt_i       (rt_q),
    .id_ex_dest_i     (id_ex_dest),
    .if_id_rs_i       (IF_ID_Reg_Rs),
    .if_id_rt_i       (IF_ID_Reg_Rt),
    .id_branch_i      (ID_Branch),
    .ex_mem_mem_read_i(EX_MEM_MemRead),
    .ex_mem_rd_i      (EX_MEM_Reg_Rd),
    .stall_len_o      (stall_len)
  );

  always_comb begin
    state_d      = state_q;
    stall_cnt_d  = stall_cnt_q;
    bubble       = 1'b0;
    hazard_stall = 1'b0;
    case (state_q)
      RUN: begin
        if (stall_len != 2'd0) begin
          hazard_stall = 1'b1;
          bubble       = 1'b1;
          if (stall_len == 2'd2) begin
            state_d     = STALL;
            stall_cnt_d = 2'd1;
          end
        end
      end
      STALL: begin
        hazard_stall = 1'b1;
        bubble       = 1'b1;
        stall_cnt_d  = stall_cnt_q - 2'd1;
        if (stall_cnt_d == 2'd0) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    // Flush kills the capture and any pending stall, but leaves PC/IF_ID enables alone.
    if (ID_EX_Flush) begin
      bubble      = 1'b1;
      state_d     = RUN;
      stall_cnt_d = 2'd0;
    end
    ctrl_d         = bubble ? CTRL_BUBBLE : id_ctrl;
    stall_cycles_d = (hazard_stall && (stall_cycles_q != 32'hFFFF_FFFF)) ?
                     stall_cycles_q + 32'd1 : stall_cycles_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      stall_cnt_q    <= 2'd0;
      ctrl_q         <= CTRL_BUBBLE;
      rs_q           <= '0;
      rt_q           <= '0;
      rd_q           <= '0;
      rs_data_q      <= '0;
      rt_data_q      <= '0;
      imm_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cnt_q    <= stall_cnt_d;
      ctrl_q         <= ctrl_d;
      rs_q           <= IF_ID_Reg_Rs;
      rt_q           <= IF_ID_Reg_Rt;
      rd_q           <= IF_ID_Reg_Rd;
      rs_data_q      <= ID_Rs_Data;
      rt_data_q      <= ID_Rt_Data;
      imm_q          <= ID_Imm;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign PC_Write       = ~hazard_stall;
  assign IF_ID_Write    = ~hazard_stall;
  assign Hazard_Stall   = hazard_stall;
  assign ID_EX_Reg_Rs   = rs_q;
  assign ID_EX_Reg_Rt   = rt_q;
  assign ID_EX_Reg_Rd   = rd_q;
  assign ID_EX_Rs_Data  = rs_data_q;
  assign ID_EX_Rt_Data  = rt_data_q;
  assign ID_EX_Imm      = imm_q;
  assign ID_EX_RegWrite = ctrl_q.reg_write;
  assign ID_EX_MemRead  = ctrl_q.mem_read;
  assign ID_EX_MemWrite = ctrl_q.mem_write;
  assign ID_EX_MemtoReg = ctrl_q.mem_to_reg;
  assign ID_EX_RegDst   = ctrl_q.reg_dst;
  assign ID_EX_ALUSrc   = ctrl_q.alu_src;
  assign ID_EX_Branch   = ctrl_q.branch;
  assign ID_EX_ALUOp    = ctrl_q.alu_op;
  assign Stall_Cycles   = stall_cycles_q;

endmodule

// File: tb/tb_hazard_id_ex_stage.sv
// Scoreboard bench for hazard_id_ex_stage; expectations follow ID_BRANCH_HAZARD_EN.
module tb_hazard_id_ex_stage;

`ifdef ID_BRANCH_HAZARD_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  // {RegWrite, MemRead, MemWrite, MemtoReg, RegDst, ALUSrc, Branch, ALUOp[1:0]}
  localparam logic [8:0] C_LW  = 9'b1_1_0_1_0_1_0_00;
  localparam logic [8:0] C_ADD = 9'b1_0_0_0_1_0_0_10;
  localparam logic [8:0] C_BEQ = 9'b0_0_0_0_0_0_1_01;
  localparam logic [8:0] C_NOP = 9'b0;

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic [8:0]  ctrl;
    logic [4:0]  mrd;
    logic        mrd_rd;
    logic        flush;
    logic        rst;
  } stim_t;

  typedef struct {
    logic        chk_comb, pcw, hz;
    logic [8:0]  ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm, cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0]  if_rs, if_rt, if_rd, mem_rd;
  logic [31:0] rs_data, rt_data, imm;
  logic [8:0]  ctrl_in;
  logic        mem_memread, flush;
  logic        pc_write, if_id_write, hz_stall;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rsd, ex_rtd, ex_imm, stall_cycles;
  logic        ex_rw, ex_mr, ex_mw, ex_m2r, ex_rdst, ex_as, ex_br;
  logic [1:0]  ex_aluop;

  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;
  logic [31:0] cnt_m = 0;
  exp_t exp_q[$];
  stim_t s;

  always #5 clk = ~clk;

  hazard_id_ex_stage dut (
    .clk(clk), .reset(reset),
    .IF_ID_Reg_Rs(if_rs), .IF_ID_Reg_Rt(if_rt), .IF_ID_Reg_Rd(if_rd),
    .ID_Rs_Data(rs_data), .ID_Rt_Data(rt_data), .ID_Imm(imm),
    .ID_RegWrite(ctrl_in[8]), .ID_MemRead(ctrl_in[7]), .ID_MemWrite(ctrl_in[6]),
    .ID_MemtoReg(ctrl_in[5]), .ID_RegDst(ctrl_in[4]), .ID_ALUSrc(ctrl_in[3]),
    .ID_Branch(ctrl_in[2]), .ID_ALUOp(ctrl_in[1:0]),
    .EX_MEM_Reg_Rd(mem_rd), .EX_MEM_MemRead(mem_memread), .ID_EX_Flush(flush),
    .PC_Write(pc_write), .IF_ID_Write(if_id_write), .Hazard_Stall(hz_stall),
    .ID_EX_Reg_Rs(ex_rs), .ID_EX_Reg_Rt(ex_rt), .ID_EX_Reg_Rd(ex_rd),
    .ID_EX_Rs_Data(ex_rsd), .ID_EX_Rt_Data(ex_rtd), .ID_EX_Imm(ex_imm),
    .ID_EX_RegWrite(ex_rw), .ID_EX_MemRead(ex_mr), .ID_EX_MemWrite(ex_mw),
    .ID_EX_MemtoReg(ex_m2r), .ID_EX_RegDst(ex_rdst), .ID_EX_ALUSrc(ex_as),
    .ID_EX_Branch(ex_br), .ID_EX_ALUOp(ex_aluop),
    .Stall_Cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL step%0d %s got=%0h want=%0h", step_no, tag, got, want);
    end
  endtask

  function automatic stim_t mk(input logic [8:0] c, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd);
    stim_t r;
    r.rs = rs; r.rt = rt; r.rd = rd;
    r.rsd = $urandom; r.rtd = $urandom; r.imm = $urandom;
    r.ctrl = c; r.mrd = 5'd0; r.mrd_rd = 1'b0; r.flush = 1'b0; r.rst = 1'b0;
    return r;
  endfunction

  // One cycle: drive at negedge, check hazard outputs mid-cycle, registers after the edge.
  task automatic step(input stim_t st, input bit bub, input bit stall, input bit chk_comb);
    exp_t e, g;
    @(negedge clk);
    step_no++;
    reset = st.rst; if_rs = st.rs; if_rt = st.rt; if_rd = st.rd;
    rs_data = st.rsd; rt_data = st.rtd; imm = st.imm; ctrl_in = st.ctrl;
    mem_rd = st.mrd; mem_memread = st.mrd_rd; flush = st.flush;
    e.chk_comb = chk_comb; e.pcw = ~stall; e.hz = stall;
    if (st.rst) begin
      e.ctrl = '0; e.rs = '0; e.rt = '0; e.rd = '0;
      e.rsd = '0; e.rtd = '0; e.imm = '0; cnt_m = '0;
    end else begin
      e.ctrl = bub ? 9'd0 : st.ctrl;
      e.rs = st.rs; e.rt = st.rt; e.rd = st.rd;
      e.rsd = st.rsd; e.rtd = st.rtd; e.imm = st.imm;
      if (stall && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
    end
    e.cnt = cnt_m;
    exp_q.push_back(e);
    #2;
    g = exp_q.pop_front();
    if (g.chk_comb) begin
      chk("pc_write", {31'd0, pc_write}, {31'd0, g.pcw});
      chk("if_id_write", {31'd0, if_id_write}, {31'd0, g.pcw});
      chk("hazard_stall", {31'd0, hz_stall}, {31'd0, g.hz});
    end
    @(posedge clk);
    #1;
    chk("ctrl", {23'd0, ex_rw, ex_mr, ex_mw, ex_m2r, ex_rdst, ex_as, ex_br, ex_aluop},
        {23'd0, g.ctrl});
    chk("regs", {17'd0, ex_rs, ex_rt, ex_rd}, {17'd0, g.rs, g.rt, g.rd});
    chk("rs_data", ex_rsd, g.rsd);
    chk("rt_data", ex_rtd, g.rtd);
    chk("imm", ex_imm, g.imm);
    chk("stall_cycles", stall_cycles, g.cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; ctrl_in = '0; mem_rd = '0; mem_memread = 1'b0;
    if_rs = '0; if_rt = '0; if_rd = '0; rs_data = '0; rt_data = '0; imm = '0;

    s = mk(C_LW, 5'd3, 5'd9, 5'd1); s.rst = 1'b1;
    step(s, 0, 0, 0);
    step(s, 0, 0, 1);

    // load r2 then use r2 as Rs: one bubble
    step(mk(C_LW, 5'd1, 5'd2, 5'd0), 0, 0, 1);
    s = mk(C_ADD, 5'd2, 5'd3, 5'd4);
    step(s, 1, 1, 1);
    step(s, 0, 0, 1);

    // load r0 then use r0: never a hazard
    step(mk(C_LW, 5'd1, 5'd0, 5'd0), 0, 0, 1);
    step(mk(C_ADD, 5'd0, 5'd0, 5'd6), 0, 0, 1);

    // load-use on Rt
    step(mk(C_LW, 5'd1, 5'd7, 5'd0), 0, 0, 1);
    s = mk(C_ADD, 5'd9, 5'd7, 5'd8);
    step(s, 1, 1, 1);
    step(s, 0, 0, 1);

    // add r4 (RegDst) in EX, beq on r4
    step(mk(C_ADD, 5'd1, 5'd2, 5'd4), 0, 0, 1);
    s = mk(C_BEQ, 5'd4, 5'd0, 5'd0);
    step(s, BR, BR, 1);
    step(s, 0, 0, 1);

    // load r6 in MEM, beq on r6
    s = mk(C_BEQ, 5'd6, 5'd1, 5'd0); s.mrd = 5'd6; s.mrd_rd = 1'b1;
    step(s, BR, BR, 1);
    s.mrd_rd = 1'b0;
    step(s, 0, 0, 1);

    // load r5 in EX, beq on r5: two bubbles with the branch rules, one without
    step(mk(C_LW, 5'd1, 5'd5, 5'd0), 0, 0, 1);
    s = mk(C_BEQ, 5'd5, 5'd3, 5'd0);
    step(s, 1, 1, 1);
    step(s, BR, BR, 1);
    step(s, 0, 0, 1);

    // flush on the cycle after the first bubble
    step(mk(C_LW, 5'd1, 5'd5, 5'd0), 0, 0, 1);
    s = mk(C_BEQ, 5'd5, 5'd3, 5'd0);
    step(s, 1, 1, 1);
    s.flush = 1'b1;
    step(s, 1, BR, 1);
    s.flush = 1'b0;
    step(s, 0, 0, 1);

    // reset on the cycle after the first bubble
    step(mk(C_LW, 5'd1, 5'd5, 5'd0), 0, 0, 1);
    s = mk(C_BEQ, 5'd5, 5'd3, 5'd0);
    step(s, 1, 1, 1);
    s.rst = 1'b1;
    step(s, 0, BR, 1);
    step(mk(C_NOP, 5'd0, 5'd0, 5'd0), 0, 0, 1);

    // counter saturation
    @(negedge clk);
    force dut.stall_cycles_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cycles_q;
    cnt_m = 32'hFFFF_FFFF;
    step(mk(C_LW, 5'd1, 5'd2, 5'd0), 0, 0, 1);
    s = mk(C_ADD, 5'd2, 5'd3, 5'd4);
    step(s, 1, 1, 1);
    step(s, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
